program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 274 +++++++++++++++++++++++++++
 tb/tb_program_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Receives a byte stream holding a program image and writes it into the
// instruction and data memories. Once the whole image is written, it releases
// the core.
//
// Stream layout (little-endian throughout):
//   ICNT (2 bytes), ICNT x 32-bit instruction words,
//   DCNT (2 bytes), DCNT x 64-bit data words.
// A header count larger than the matching memory size sends the loader to a
// sticky error state. Only reset leaves that state.
//
// Ports:
//   clk          single clock, rising edge
//   arst_n       active-low reset, sampled synchronously on clk
//   start        begin a load session (honoured in IDLE only)
//   in_valid     stream source has a byte
//   in_data      stream byte
//   in_ready     loader can take a byte this cycle
//   addr_ext     instruction-memory byte address
//   wen_ext      instruction-memory write strobe (one cycle per word)
//   wdata_ext    instruction word
//   addr_ext_2   data-memory byte address
//   wen_ext_2    data-memory write strobe (one cycle per word)
//   wdata_ext_2  data word
//   cpu_enable   core enable, high once the image is fully loaded
//   busy         load session in progress
//   error        sticky header-count overflow
// -----------------------------------------------------------------------------
module program_loader #(
   parameter int IMEM_WORDS = 512,
   parameter int DMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic [31:0] wdata_ext,
   output logic [63:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic [63:0] wdata_ext_2,
   output logic        cpu_enable,
   output logic        busy,
   output logic        error
);

   localparam logic [31:0] IMEM_LIMIT = IMEM_WORDS;
   localparam logic [31:0] DMEM_LIMIT = DMEM_WORDS;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_IHDR   = 4'd1,
      ST_IWORD  = 4'd2,
      ST_IWRITE = 4'd3,
      ST_DHDR   = 4'd4,
      ST_DWORD  = 4'd5,
      ST_DWRITE = 4'd6,
      ST_RUN    = 4'd7,
      ST_ERR    = 4'd8
   } state_t;

   state_t        state_r;
   state_t        state_next_s;

   logic [2:0]    byte_cnt_r;     // byte position within header or word
   logic [15:0]   word_cnt_r;     // word index within current section
   logic [7:0]    hdr_lo_r;       // low byte of the header being received
   logic [15:0]   cnt_r;          // word count of the current section

   logic          in_ready_r;
   logic          busy_r;
   logic          cpu_enable_r;
   logic          error_r;
   logic          wen_ext_r;
   logic          wen_ext_2_r;
   logic [63:0]   addr_ext_r;
   logic [31:0]   wdata_ext_r;
   logic [63:0]   addr_ext_2_r;
   logic [63:0]   wdata_ext_2_r;

   logic          accept_s;
   logic [31:0]   hdr_val_s;
   logic          last_word_s;
   logic          state_change_s;

   // in_ready_r is a registered decode of the current state, so it qualifies the transfer directly
   assign accept_s       = in_valid & in_ready_r;
   assign hdr_val_s      = {16'd0, in_data, hdr_lo_r};
   assign last_word_s    = (word_cnt_r == (cnt_r - 16'd1));
   assign state_change_s = (state_next_s != state_r);

   // next-state selection
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_IHDR;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_IHDR: begin
            if (accept_s && (byte_cnt_r == 3'd1)) begin
               if (hdr_val_s > IMEM_LIMIT) begin
                  state_next_s = ST_ERR;
               end else if (hdr_val_s == 32'd0) begin
                  state_next_s = ST_DHDR;
               end else begin
                  state_next_s = ST_IWORD;
               end
            end else begin
               state_next_s = ST_IHDR;
            end
         end
         ST_IWORD: begin
            if (accept_s && (byte_cnt_r == 3'd3)) begin
               state_next_s = ST_IWRITE;
            end else begin
               state_next_s = ST_IWORD;
            end
         end
         ST_IWRITE: begin
            if (last_word_s) begin
               state_next_s = ST_DHDR;
            end else begin
               state_next_s = ST_IWORD;
            end
         end
         ST_DHDR: begin
            if (accept_s && (byte_cnt_r == 3'd1)) begin
               if (hdr_val_s > DMEM_LIMIT) begin
                  state_next_s = ST_ERR;
               end else if (hdr_val_s == 32'd0) begin
                  state_next_s = ST_RUN;
               end else begin
                  state_next_s = ST_DWORD;
               end
            end else begin
               state_next_s = ST_DHDR;
            end
         end
         ST_DWORD: begin
            if (accept_s && (byte_cnt_r == 3'd7)) begin
               state_next_s = ST_DWRITE;
            end else begin
               state_next_s = ST_DWORD;
            end
         end
         ST_DWRITE: begin
            if (last_word_s) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_DWORD;
            end
         end
         ST_RUN:  state_next_s = ST_RUN;
         ST_ERR:  state_next_s = ST_ERR;
         default: state_next_s = ST_ERR;
      endcase
   end

   // state register and status outputs, decoded from the next state so they align with it
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_r      <= ST_IDLE;
         in_ready_r   <= 1'b0;
         busy_r       <= 1'b0;
         cpu_enable_r <= 1'b0;
         error_r      <= 1'b0;
         wen_ext_r    <= 1'b0;
         wen_ext_2_r  <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         in_ready_r   <= (state_next_s == ST_IHDR)  || (state_next_s == ST_IWORD) ||
                         (state_next_s == ST_DHDR)  || (state_next_s == ST_DWORD);
         busy_r       <= (state_next_s != ST_IDLE)  && (state_next_s != ST_RUN) &&
                         (state_next_s != ST_ERR);
         cpu_enable_r <= (state_next_s == ST_RUN);
         error_r      <= (state_next_s == ST_ERR);
         wen_ext_r    <= (state_next_s == ST_IWRITE);
         wen_ext_2_r  <= (state_next_s == ST_DWRITE);
      end
   end

   // counters, header capture and word assembly
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         byte_cnt_r    <= 3'd0;
         word_cnt_r    <= 16'd0;
         hdr_lo_r      <= 8'd0;
         cnt_r         <= 16'd0;
         addr_ext_r    <= 64'd0;
         wdata_ext_r   <= 32'd0;
         addr_ext_2_r  <= 64'd0;
         wdata_ext_2_r <= 64'd0;
      end else begin
         // byte position restarts on every state entry and never wraps on its own
         if (state_change_s) begin
            byte_cnt_r <= 3'd0;
         end else if (accept_s) begin
            byte_cnt_r <= byte_cnt_r + 3'd1;
         end else begin
            byte_cnt_r <= byte_cnt_r;
         end

         if ((state_r == ST_IHDR) || (state_r == ST_DHDR)) begin
            if (accept_s && (byte_cnt_r == 3'd0)) begin
               hdr_lo_r <= in_data;
            end else if (accept_s && (byte_cnt_r == 3'd1)) begin
               cnt_r <= {in_data, hdr_lo_r};
            end else begin
               hdr_lo_r <= hdr_lo_r;
            end
         end else begin
            hdr_lo_r <= hdr_lo_r;
         end

         // word index restarts when a section header begins, advances once per write
         if (state_change_s &&
             ((state_next_s == ST_IHDR) || (state_next_s == ST_DHDR))) begin
            word_cnt_r <= 16'd0;
         end else if ((state_r == ST_IWRITE) || (state_r == ST_DWRITE)) begin
            word_cnt_r <= word_cnt_r + 16'd1;
         end else begin
            word_cnt_r <= word_cnt_r;
         end

         // bytes land directly in the output word, so the previous word stays
         // visible until the first byte of the next one arrives
         if ((state_r == ST_IWORD) && accept_s) begin
            wdata_ext_r[{byte_cnt_r[1:0], 3'b000} +: 8] <= in_data;
         end else begin
            wdata_ext_r <= wdata_ext_r;
         end

         if ((state_r == ST_DWORD) && accept_s) begin
            wdata_ext_2_r[{byte_cnt_r, 3'b000} +: 8] <= in_data;
         end else begin
            wdata_ext_2_r <= wdata_ext_2_r;
         end

         // address is loaded together with the strobe and held until the next strobe
         if (state_next_s == ST_IWRITE) begin
            addr_ext_r <= {46'd0, word_cnt_r, 2'b00};
         end else begin
            addr_ext_r <= addr_ext_r;
         end

         if (state_next_s == ST_DWRITE) begin
            addr_ext_2_r <= {45'd0, word_cnt_r, 3'b000};
         end else begin
            addr_ext_2_r <= addr_ext_2_r;
         end
      end
   end

   assign in_ready    = in_ready_r;
   assign busy        = busy_r;
   assign cpu_enable  = cpu_enable_r;
   assign error       = error_r;
   assign wen_ext     = wen_ext_r;
   assign wen_ext_2   = wen_ext_2_r;
   assign addr_ext    = addr_ext_r;
   assign wdata_ext   = wdata_ext_r;
   assign addr_ext_2  = addr_ext_2_r;
   assign wdata_ext_2 = wdata_ext_2_r;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed bench for program_loader. It sends hand-built byte streams and
// records every write strobe seen on the falling clock edge. Each recorded
// write is compared against hand-computed addresses and data.
// -----------------------------------------------------------------------------
module tb_program_loader;

   logic        clk;
   logic        arst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic [63:0] wdata_ext_2;
   logic        cpu_enable;
   logic        busy;
   logic        error;

   int total_cnt;
   int bad_cnt;

   logic [63:0] iw_addr_q[$];
   logic [63:0] iw_data_q[$];
   logic [63:0] dw_addr_q[$];
   logic [63:0] dw_data_q[$];
   logic [7:0]  stream_q[$];

   program_loader #(
      .IMEM_WORDS (512),
      .DMEM_WORDS (1024)
   ) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .start       (start),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .addr_ext    (addr_ext),
      .wen_ext     (wen_ext),
      .wdata_ext   (wdata_ext),
      .addr_ext_2  (addr_ext_2),
      .wen_ext_2   (wen_ext_2),
      .wdata_ext_2 (wdata_ext_2),
      .cpu_enable  (cpu_enable),
      .busy        (busy),
      .error       (error)
   );

   // free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt = total_cnt + 1;
      if (obs !== exp) begin
         bad_cnt = bad_cnt + 1;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // strobe monitor: record writes, check handshake rules on every strobe cycle
   always @(negedge clk) begin
      if (wen_ext || wen_ext_2) begin
         check_val("ready_on_strobe", {63'd0, in_ready}, 64'd0);
         check_val("both_strobes", {63'd0, wen_ext & wen_ext_2}, 64'd0);
      end
      if (wen_ext) begin
         iw_addr_q.push_back(addr_ext);
         iw_data_q.push_back({32'd0, wdata_ext});
      end
      if (wen_ext_2) begin
         dw_addr_q.push_back(addr_ext_2);
         dw_data_q.push_back(wdata_ext_2);
      end
   end

   task automatic clear_log();
      iw_addr_q.delete();
      iw_data_q.delete();
      dw_addr_q.delete();
      dw_data_q.delete();
   endtask

   task automatic do_reset();
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;
      arst_n   = 1'b0;
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      clear_log();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // offer one byte and hold it until the loader takes it, bounded by a cycle budget
   task automatic send_byte(input logic [7:0] b);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         check_val("byte_timeout", 64'd0, 64'd1);
      end
   endtask

   task automatic send_stream(input bit stall);
      for (int i = 0; i < stream_q.size(); i++) begin
         if (stall) begin
            while ($urandom_range(0, 1) == 1) begin
               @(posedge clk);
               #1;
            end
         end
         send_byte(stream_q[i]);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // single instruction word, no data
   task automatic run_one_word();
      stream_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h00, 8'h00};
      pulse_start();
      send_stream(1'b0);
      @(negedge clk);
      check_val("w1_cpu_en", {63'd0, cpu_enable}, 64'd1);
      idle_cycles(3);
      check_val("w1_icount", 64'(iw_addr_q.size()), 64'd1);
      check_val("w1_dcount", 64'(dw_addr_q.size()), 64'd0);
      if (iw_addr_q.size() == 1) begin
         check_val("w1_addr", iw_addr_q[0], 64'd0);
         check_val("w1_data", iw_data_q[0], 64'h0000_0000_0010_0513);
      end
      check_val("w1_busy", {63'd0, busy}, 64'd0);
      check_val("w1_error", {63'd0, error}, 64'd0);
   endtask

   task automatic run_two_plus_one(input bit stall, input string tag);
      stream_q = '{8'h02, 8'h00,
                   8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05, 8'h20, 8'h00,
                   8'h01, 8'h00,
                   8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      pulse_start();
      send_stream(stall);
      idle_cycles(3);
      check_val({tag, "_icount"}, 64'(iw_addr_q.size()), 64'd2);
      check_val({tag, "_dcount"}, 64'(dw_addr_q.size()), 64'd1);
      if (iw_addr_q.size() == 2) begin
         check_val({tag, "_iaddr0"}, iw_addr_q[0], 64'd0);
         check_val({tag, "_idata0"}, iw_data_q[0], 64'h0000_0000_0010_0513);
         check_val({tag, "_iaddr1"}, iw_addr_q[1], 64'd4);
         check_val({tag, "_idata1"}, iw_data_q[1], 64'h0000_0000_0020_0593);
      end
      if (dw_addr_q.size() == 1) begin
         check_val({tag, "_daddr0"}, dw_addr_q[0], 64'd0);
         check_val({tag, "_ddata0"}, dw_data_q[0], 64'h0807_0605_0403_0201);
      end
      check_val({tag, "_cpu_en"}, {63'd0, cpu_enable}, 64'd1);
      check_val({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
   endtask

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      arst_n    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      arst_n = 1'b1;

      // reset state
      @(negedge clk);
      check_val("rst_ready", {63'd0, in_ready}, 64'd0);
      check_val("rst_busy", {63'd0, busy}, 64'd0);
      check_val("rst_cpu_en", {63'd0, cpu_enable}, 64'd0);
      check_val("rst_error", {63'd0, error}, 64'd0);
      check_val("rst_wen", {62'd0, wen_ext, wen_ext_2}, 64'd0);
      idle_cycles(1);

      // idle without start: stays idle and never ready
      idle_cycles(2);
      check_val("idle_ready", {63'd0, in_ready}, 64'd0);

      // one instruction word
      do_reset();
      run_one_word();

      // start in RUN is ignored
      pulse_start();
      @(negedge clk);
      check_val("run_start_cpu", {63'd0, cpu_enable}, 64'd1);
      check_val("run_start_busy", {63'd0, busy}, 64'd0);

      // two instructions plus one data word, back-to-back then with random stalls
      do_reset();
      run_two_plus_one(1'b0, "seq");
      do_reset();
      run_two_plus_one(1'b1, "stall");

      // ICNT = 513 exceeds the instruction memory
      do_reset();
      stream_q = '{8'h01, 8'h02};
      pulse_start();
      send_stream(1'b0);
      idle_cycles(3);
      @(negedge clk);
      check_val("iovf_error", {63'd0, error}, 64'd1);
      check_val("iovf_ready", {63'd0, in_ready}, 64'd0);
      check_val("iovf_cpu_en", {63'd0, cpu_enable}, 64'd0);
      check_val("iovf_busy", {63'd0, busy}, 64'd0);
      check_val("iovf_strobes", 64'(iw_addr_q.size() + dw_addr_q.size()), 64'd0);

      // ICNT = 512 is exactly at the limit and is accepted
      do_reset();
      stream_q = '{8'h00, 8'h02};
      pulse_start();
      send_stream(1'b0);
      @(negedge clk);
      check_val("ilim_error", {63'd0, error}, 64'd0);
      check_val("ilim_ready", {63'd0, in_ready}, 64'd1);
      check_val("ilim_busy", {63'd0, busy}, 64'd1);

      // DCNT = 1025 exceeds the data memory
      do_reset();
      stream_q = '{8'h00, 8'h00, 8'h01, 8'h04};
      pulse_start();
      send_stream(1'b0);
      @(negedge clk);
      check_val("dovf_error", {63'd0, error}, 64'd1);
      check_val("dovf_cpu_en", {63'd0, cpu_enable}, 64'd0);

      // reset after the third byte of an instruction word
      do_reset();
      stream_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10};
      pulse_start();
      send_stream(1'b0);
      arst_n = 1'b0;
      @(posedge clk);
      #1;
      check_val("mid_busy", {63'd0, busy}, 64'd0);
      check_val("mid_ready", {63'd0, in_ready}, 64'd0);
      check_val("mid_wdata", {32'd0, wdata_ext}, 64'd0);
      check_val("mid_addr", addr_ext, 64'd0);
      check_val("mid_wen", {62'd0, wen_ext, wen_ext_2}, 64'd0);
      arst_n = 1'b1;
      idle_cycles(3);
      check_val("mid_strobes", 64'(iw_addr_q.size() + dw_addr_q.size()), 64'd0);
      run_one_word();

      // empty image: RUN right after the fourth byte
      do_reset();
      stream_q = '{8'h00, 8'h00, 8'h00, 8'h00};
      pulse_start();
      send_stream(1'b0);
      @(negedge clk);
      check_val("empty_cpu_en", {63'd0, cpu_enable}, 64'd1);
      check_val("empty_strobes", 64'(iw_addr_q.size() + dw_addr_q.size()), 64'd0);

      // reset from RUN drops the enable
      arst_n = 1'b0;
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      check_val("run_rst_cpu_en", {63'd0, cpu_enable}, 64'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
